// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the fetch-stage state type.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned IMM_BIT_DEF = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP_ISSUE,
        S_OP_WAIT,
        S_IMM_ISSUE,
        S_IMM_WAIT,
        S_HOLD
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads opcode (+ optional immediate) from program
// memory over req/ack, pulses the PC increment and hands the result to decode.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned IMM_BIT = IMM_BIT_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_run,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_pcAddr,
    output logic              o_pcOe,
    output logic              o_pcIncr,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic              o_memReq,
    input  logic              i_memAck,
    input  logic [DATA_W-1:0] i_memData,
    output logic              o_instrValid,
    input  logic              i_instrReady,
    output logic [DATA_W-1:0] o_opcode,
    output logic [DATA_W-1:0] o_imm,
    output logic              o_hasImm
);

    fetch_state_t      state_q, state_d;
    logic              flush_pend_q, flush_pend_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              discard;

    // A flush seen during a wait, or coinciding with the ack, voids that read.
    assign discard = flush_pend_q | i_flush;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            flush_pend_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            opcode_q     <= '0;
            imm_q        <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            opcode_q     <= opcode_d;
            imm_q        <= imm_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        mem_addr_d   = mem_addr_q;
        mem_req_d    = mem_req_q;
        opcode_d     = opcode_q;
        imm_d        = imm_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_run) state_d = S_OP_ISSUE;
            end
            S_OP_ISSUE, S_IMM_ISSUE: begin
                if (i_flush) begin
                    state_d = S_OP_ISSUE;
                end else begin
                    mem_addr_d = i_pcAddr;
                    mem_req_d  = 1'b1;
                    state_d    = (state_q == S_OP_ISSUE) ? S_OP_WAIT : S_IMM_WAIT;
                end
            end
            S_OP_WAIT: begin
                if (i_memAck) begin
                    mem_req_d    = 1'b0;
                    flush_pend_d = 1'b0;
                    if (discard) begin
                        state_d = S_OP_ISSUE;
                    end else begin
                        opcode_d = i_memData;
                        imm_d    = '0;
                        state_d  = i_memData[IMM_BIT] ? S_IMM_ISSUE : S_HOLD;
                    end
                end else if (i_flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            S_IMM_WAIT: begin
                if (i_memAck) begin
                    mem_req_d    = 1'b0;
                    flush_pend_d = 1'b0;
                    if (discard) begin
                        state_d = S_OP_ISSUE;
                    end else begin
                        imm_d   = i_memData;
                        state_d = S_HOLD;
                    end
                end else if (i_flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_flush) begin
                    state_d = S_OP_ISSUE;
                end else if (i_instrReady) begin
                    state_d = i_run ? S_OP_ISSUE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_pcOe       = 1'b0;
        o_pcIncr     = 1'b0;
        o_instrValid = 1'b0;
        unique case (state_q)
            S_OP_ISSUE, S_IMM_ISSUE: o_pcOe = 1'b1;
            S_OP_WAIT, S_IMM_WAIT:   o_pcIncr = i_memAck & ~discard;
            S_HOLD:                  o_instrValid = 1'b1;
            default: ;
        endcase
    end

    assign o_memAddr = mem_addr_q;
    assign o_memReq  = mem_req_q;
    assign o_opcode  = opcode_q;
    assign o_imm     = imm_q;
    assign o_hasImm  = opcode_q[IMM_BIT];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, multi-cycle
// corner sequences and a randomized run against an instruction-level model.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       i_reset_n, i_run, i_flush, i_memAck, i_instrReady;
    logic [7:0] i_pcAddr, i_memData;
    logic       o_pcOe, o_pcIncr, o_memReq, o_instrValid, o_hasImm;
    logic [7:0] o_memAddr, o_opcode, o_imm;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(8), .DATA_W(8), .IMM_BIT(7)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_run(i_run), .i_flush(i_flush),
        .i_pcAddr(i_pcAddr), .o_pcOe(o_pcOe), .o_pcIncr(o_pcIncr),
        .o_memAddr(o_memAddr), .o_memReq(o_memReq), .i_memAck(i_memAck),
        .i_memData(i_memData), .o_instrValid(o_instrValid),
        .i_instrReady(i_instrReady), .o_opcode(o_opcode), .o_imm(o_imm),
        .o_hasImm(o_hasImm)
    );

    typedef struct {
        logic [7:0] pc;
        logic [7:0] op;
        logic [7:0] imm_mem;
        logic [7:0] exp_op;
        logic [7:0] exp_imm;
        logic       exp_has;
        int         lat;
        int         incr;
    } vec_t;

    logic [7:0] mem [256];
    int         n_vec = 0, n_err = 0;
    logic [7:0] flush_tgt = '0;
    int         ack_delay = 0;
    bit         rand_mode = 1'b0;
    bit         req_seen = 1'b0;
    int         wait_left = 0;
    logic [7:0] req_addr = '0;
    int         n_incr = 0, n_req = 0, n_acc = 0;
    logic [7:0] req_log [4];
    logic       s_pcoe, s_incr, s_valid, s_req;
    logic [7:0] pc_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_accept();
        logic [7:0] op, im, nxt;
        int         len;
        op  = mem[pc_model];
        nxt = 8'(pc_model + 8'd1);
        im  = op[7] ? mem[nxt] : 8'h00;
        len = op[7] ? 2 : 1;
        check("rnd_opcode", 32'(o_opcode), 32'(op));
        check("rnd_imm", 32'(o_imm), 32'(im));
        check("rnd_hasImm", 32'(o_hasImm), 32'(op[7]));
        check("rnd_pc_advance", 32'(i_pcAddr), 32'(8'(pc_model + 8'(len))));
        pc_model = 8'(pc_model + 8'(len));
        n_acc++;
    endtask

    // One clock cycle: memory responder and decisions at negedge, sample, then PC update after posedge.
    task automatic tick();
        logic [7:0] pc_nxt;
        logic       cur_valid;
        @(negedge clk);
        cur_valid = o_instrValid;
        if (rand_mode) begin
            i_instrReady = ($urandom_range(0, 3) != 0);
            i_flush      = cur_valid && ($urandom_range(0, 7) == 0);
            flush_tgt    = 8'($urandom);
        end
        if (o_memReq) begin
            if (!req_seen) begin
                req_seen  = 1'b1;
                wait_left = rand_mode ? int'($urandom_range(0, 3)) : ack_delay;
                req_addr  = o_memAddr;
                if (n_req < 4) req_log[n_req] = o_memAddr;
                n_req++;
                check("req_addr_is_pc", 32'(o_memAddr), 32'(i_pcAddr));
            end else begin
                check("req_addr_stable", 32'(o_memAddr), 32'(req_addr));
            end
            if (wait_left == 0) begin
                i_memAck  = 1'b1;
                i_memData = mem[o_memAddr];
            end else begin
                i_memAck  = 1'b0;
                i_memData = 8'($urandom);
                wait_left--;
            end
        end else begin
            req_seen  = 1'b0;
            i_memAck  = ($urandom_range(0, 3) == 0);
            i_memData = 8'($urandom);
        end
        #1;
        s_pcoe  = o_pcOe;
        s_incr  = o_pcIncr;
        s_valid = o_instrValid;
        s_req   = o_memReq;
        if (o_pcIncr) n_incr++;
        if (rand_mode && cur_valid) begin
            if (i_instrReady) model_accept();
            if (i_flush) pc_model = flush_tgt;
        end
        pc_nxt = i_flush ? flush_tgt : (o_pcIncr ? 8'(i_pcAddr + 8'd1) : i_pcAddr);
        @(posedge clk);
        #1;
        i_pcAddr = pc_nxt;
        i_flush  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k;
        for (k = 0; k < 30 && !s_valid; k++) tick();
        if (!s_valid) check({name, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic park(input string name);
        i_run        = 1'b0;
        i_instrReady = 1'b1;
        tick();
        i_instrReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check({name, "_park_idle"}, {30'd0, s_req, s_pcoe}, 32'(0));
        end
    endtask

    task automatic start_fetch(input logic [7:0] pc);
        i_pcAddr = pc;
        n_incr   = 0;
        n_req    = 0;
        s_valid  = 1'b0;
        i_instrReady = 1'b0;
        i_run    = 1'b1;
    endtask

    vec_t tbl [6];

    initial begin
        int issue_cyc, valid_cyc, req_cyc;

        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        tbl[0] = '{8'h00, 8'h12, 8'h99, 8'h12, 8'h00, 1'b0, 2, 1};
        tbl[1] = '{8'h05, 8'h83, 8'h4A, 8'h83, 8'h4A, 1'b1, 4, 2};
        tbl[2] = '{8'h10, 8'h7F, 8'hAA, 8'h7F, 8'h00, 1'b0, 2, 1};
        tbl[3] = '{8'h20, 8'h80, 8'h00, 8'h80, 8'h00, 1'b1, 4, 2};
        tbl[4] = '{8'hFF, 8'hC3, 8'h11, 8'hC3, 8'h11, 1'b1, 4, 2};
        tbl[5] = '{8'h30, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b0, 2, 1};

        i_reset_n = 1'b0; i_run = 1'b0; i_flush = 1'b0; i_memAck = 1'b0;
        i_instrReady = 1'b0; i_pcAddr = '0; i_memData = '0;
        #1;
        check("reset_req_valid_pc", {28'd0, o_memReq, o_instrValid, o_pcOe, o_pcIncr}, 32'(0));
        check("reset_opcode_imm", {16'd0, o_opcode, o_imm}, 32'(0));
        check("reset_addr_hasimm", {23'd0, o_memAddr, o_hasImm}, 32'(0));
        #20;
        i_reset_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            mem[tbl[v].pc] = tbl[v].op;
            mem[8'(tbl[v].pc + 8'd1)] = tbl[v].imm_mem;
            ack_delay = 0;
            start_fetch(tbl[v].pc);
            issue_cyc = -1;
            valid_cyc = -1;
            for (int k = 0; k < 20 && valid_cyc < 0; k++) begin
                tick();
                if (s_pcoe && issue_cyc < 0) issue_cyc = k;
                if (s_valid) valid_cyc = k;
            end
            check("tbl_latency", 32'(valid_cyc - issue_cyc), 32'(tbl[v].lat));
            check("tbl_opcode", 32'(o_opcode), 32'(tbl[v].exp_op));
            check("tbl_imm", 32'(o_imm), 32'(tbl[v].exp_imm));
            check("tbl_hasImm", 32'(o_hasImm), 32'(tbl[v].exp_has));
            check("tbl_pcIncr_count", 32'(n_incr), 32'(tbl[v].incr));
            check("tbl_req_count", 32'(n_req), 32'(tbl[v].incr));
            check("tbl_first_addr", 32'(req_log[0]), 32'(tbl[v].pc));
            if (n_req > 1) check("tbl_imm_addr", 32'(req_log[1]), 32'(8'(tbl[v].pc + 8'd1)));
            park("tbl");
        end

        // Delayed ack: request held across the wait, single increment.
        mem[8'h50] = 8'h21;
        ack_delay  = 3;
        start_fetch(8'h50);
        req_cyc = 0;
        for (int k = 0; k < 20 && !s_valid; k++) begin
            tick();
            if (s_req) req_cyc++;
        end
        check("delay_req_cycles", 32'(req_cyc), 32'(4));
        check("delay_pcIncr", 32'(n_incr), 32'(1));
        check("delay_opcode", 32'(o_opcode), 32'(8'h21));
        park("delay");

        // Flush during OP_WAIT: old data discarded, refetch from branch target.
        mem[8'h60] = 8'h33;
        mem[8'h40] = 8'h44;
        ack_delay  = 2;
        start_fetch(8'h60);
        for (int k = 0; k < 10 && !s_req; k++) tick();
        i_flush   = 1'b1;
        flush_tgt = 8'h40;
        tick();
        ack_delay = 0;
        tick();
        check("flush_ack_no_incr", 32'(s_incr), 32'(0));
        wait_valid("flush");
        check("flush_opcode", 32'(o_opcode), 32'(8'h44));
        check("flush_pcIncr", 32'(n_incr), 32'(1));
        check("flush_req_count", 32'(n_req), 32'(2));
        check("flush_target_addr", 32'(req_log[1]), 32'(8'h40));
        park("flush");

        // HOLD stall, then accept with run high, then accept with run low.
        mem[8'h70] = 8'h05;
        mem[8'h71] = 8'h06;
        ack_delay  = 0;
        start_fetch(8'h70);
        wait_valid("hold");
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_stable", {23'd0, s_valid, o_opcode}, {23'd0, 1'b1, 8'h05});
        end
        i_instrReady = 1'b1;
        tick();
        i_instrReady = 1'b0;
        tick();
        check("accept_to_issue", 32'(s_pcoe), 32'(1));
        s_valid = 1'b0;
        wait_valid("hold2");
        check("hold2_opcode", 32'(o_opcode), 32'(8'h06));
        check("hold2_addr", 32'(o_memAddr), 32'(8'h71));
        park("hold");

        // Async reset while waiting on the immediate byte.
        mem[8'h80] = 8'h90;
        mem[8'h81] = 8'h55;
        ack_delay  = 0;
        start_fetch(8'h80);
        for (int k = 0; k < 20 && n_req < 1; k++) tick();
        ack_delay = 10;
        for (int k = 0; k < 20 && n_req < 2; k++) tick();
        tick();
        check("pre_reset_opcode", 32'(o_opcode), 32'(8'h90));
        i_reset_n = 1'b0;
        i_memAck  = 1'b0;
        req_seen  = 1'b0;
        #1;
        check("async_reset_req_valid", {30'd0, o_memReq, o_instrValid}, 32'(0));
        check("async_reset_opcode_imm", {16'd0, o_opcode, o_imm}, 32'(0));
        i_run = 1'b0;
        tick();
        tick();
        i_reset_n = 1'b1;
        tick();
        tick();
        check("post_reset_idle", {30'd0, s_req, s_pcoe}, 32'(0));
        i_run = 1'b1;
        tick();
        tick();
        check("post_reset_issue", 32'(s_pcoe), 32'(1));
        ack_delay = 0;
        s_valid   = 1'b0;
        wait_valid("post_reset");
        park("post_reset");

        // Randomized run against the instruction-level model.
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        i_pcAddr  = 8'($urandom);
        pc_model  = i_pcAddr;
        n_acc     = 0;
        rand_mode = 1'b1;
        i_run     = 1'b1;
        for (int k = 0; k < 3000; k++) tick();
        rand_mode = 1'b0;
        check("rnd_progress", 32'(n_acc >= 100), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
